fe_ci_initiator: RTL and testbench
==================================

Name: fe_ci_initiator

Overview:
- Initiator side of the custom-instruction handshake (clk_en/start/n/dataa/datab → done/result) used by the function-evaluation accumulator.
- Takes a job of N float samples from a valid/ready stream and issues one CLEAR, then one GO per sample pair, then one READ.
- Returns the READ result on a valid/ready output. Lets fabric logic, rather than the CPU, drive the evaluator.

Parameters:
FLT_DATA_WIDTH, 32, width of sample, operand and result words
N_WIDTH, 2, width of the function-select field
CNT_WIDTH, 16, width of the job sample count
TIMEOUT_CYCLES, 1024, watchdog limit per instruction (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
job_start  in  1  one-cycle request to begin a job; sampled only in IDLE
job_count  in  CNT_WIDTH  number of samples in the job; captured with job_start
sample_valid  in  1  sample stream valid
sample_data  in  FLT_DATA_WIDTH  IEEE-754 single sample
sample_ready  out  1  sample accepted when valid&ready
res_valid  out  1  job result valid
res_data  out  FLT_DATA_WIDTH  value returned by READ
res_ready  in  1  result consumer ready
busy  out  1  high from job acceptance until result handoff
error  out  1  sticky timeout flag (optional feature only; otherwise tied 0)
ci_clk_en  out  1  custom-instruction clock enable
ci_start  out  1  one-cycle instruction launch
ci_n  out  N_WIDTH  opcode: CLEAR=0, GO=1, READ=2
ci_dataa  out  FLT_DATA_WIDTH  operand x_one
ci_datab  out  FLT_DATA_WIDTH  operand x_two
ci_done  in  1  one-cycle completion pulse from the evaluator
ci_result  in  FLT_DATA_WIDTH  evaluator result, valid with ci_done

Behaviour:
- Reset (rst low, async): state IDLE.
  - All outputs 0: busy, sample_ready, res_valid, res_data, ci_clk_en, ci_start, ci_n, ci_dataa, ci_datab, error.
  - Remaining-count register 0.
- States: IDLE, CLR_ISSUE, CLR_WAIT, LOAD_A, LOAD_B, GO_ISSUE, GO_WAIT, RD_ISSUE, RD_WAIT, OUTPUT.
- IDLE:
  - On job_start, capture job_count into remaining and set busy=1 and ci_clk_en=1.
  - Next state CLR_ISSUE. ci_start rises the cycle after job_start.
- *_ISSUE states:
  - Drive ci_start=1 for exactly one cycle with ci_n set to the opcode.
  - Next state is the matching *_WAIT.
  - ci_n, ci_dataa and ci_datab stay stable from ISSUE until ci_done.
- *_WAIT states:
  - Hold until ci_done=1.
  - ci_done outside a WAIT state is ignored.
  - ci_done in the same cycle as ci_start cannot occur; it is ignored if it does.
- CLR_WAIT exit: to LOAD_A if remaining>0, else RD_ISSUE.
- LOAD_A:
  - sample_ready=1. On handshake, latch ci_dataa and decrement remaining.
  - If remaining was 1, set ci_datab=0x00000000 (pad) and go to GO_ISSUE; else go to LOAD_B.
- LOAD_B:
  - sample_ready=1. On handshake, latch ci_datab, decrement remaining, go to GO_ISSUE.
- sample_ready is registered and high only in LOAD_A/LOAD_B. sample_valid low stalls indefinitely with no timeout.
- GO_WAIT exit: to LOAD_A if remaining>0, else RD_ISSUE.
- RD_WAIT: on ci_done, latch ci_result into res_data, set res_valid=1, go to OUTPUT.
- OUTPUT:
  - Hold res_valid/res_data until res_ready.
  - On handshake, clear res_valid, busy and ci_clk_en; return to IDLE.
  - res_ready high on the entry cycle completes the handoff in one cycle.
- job_start while busy: ignored, not queued.
- Instruction count per job: 1 CLEAR + ceil(N/2) GO + 1 READ. N=0 gives CLEAR then READ.
- Reset mid-job aborts immediately; any partial instruction is dropped with no cleanup.
- ci_clk_en stays 1 for the whole job, including stalls.

Optional Feature:
- Macro: FE_CI_TIMEOUT_EN.
- When defined:
  - A counter runs in each *_WAIT state.
  - If ci_done is absent for TIMEOUT_CYCLES cycles, set error=1 (sticky until reset), set res_data=0xFFFFFFFF, and go to OUTPUT with res_valid=1.
  - The counter clears on every ISSUE.
- When undefined: no counter, WAIT states wait forever, error tied 0.

Test Plan:
- job_count=4, samples 1.0,2.0,3.0,4.0 (0x3F800000…0x40800000), evaluator model done 3 cycles after start → exact sequence CLEAR; GO(a=1.0,b=2.0); GO(3.0,4.0); READ. res_data equals model READ value; busy drops on handshake.
- job_count=3 → second GO carries a=3.0, b=0x00000000; exactly 2 GOs issued.
- job_count=0 → CLEAR then READ only; sample_ready never asserted.
- sample_valid deasserted 10 cycles between samples, res_ready held low 5 cycles → no instruction issued during the gaps; res_data stable while stalled; job_start pulses while busy are ignored.
- rst pulsed low during GO_WAIT → all outputs 0 asynchronously. A new job after release starts with CLEAR.
- With FE_CI_TIMEOUT_EN, TIMEOUT_CYCLES=16, model never asserts done on READ → error=1 and res_data=0xFFFFFFFF at 16 cycles after ci_start.

Source files
------------

// File: rtl/fe_ci_initiator.sv
// fe_ci_initiator: fabric-side initiator for the function-evaluation
// custom-instruction handshake. A job of N float samples is taken from a
// valid/ready stream and turned into one CLEAR, ceil(N/2) GO instructions
// (operands paired x_one/x_two, odd tail padded with zero) and one READ,
// whose result is returned on a valid/ready output.
//
// Optional feature macro: FE_CI_TIMEOUT_EN
//   defined   : per-instruction watchdog of TIMEOUT_CYCLES cycles; on expiry
//               error is set (sticky) and 0xFFFFFFFF is returned as result.
//   undefined : WAIT states wait forever, error is tied 0.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   job_start, job_count     job request (sampled only in IDLE) and sample count
//   sample_valid/_data/_ready  sample input stream
//   res_valid/_data/_ready   job result output stream
//   busy                     high from job acceptance until result handoff
//   error                    sticky timeout flag
//   ci_clk_en, ci_start, ci_n, ci_dataa, ci_datab   instruction request
//   ci_done, ci_result       instruction completion and result
module fe_ci_initiator #(
  parameter int unsigned FLT_DATA_WIDTH = 32,
  parameter int unsigned N_WIDTH        = 2,
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      job_start,
  input  logic [CNT_WIDTH-1:0]      job_count,
  input  logic                      sample_valid,
  input  logic [FLT_DATA_WIDTH-1:0] sample_data,
  output logic                      sample_ready,
  output logic                      res_valid,
  output logic [FLT_DATA_WIDTH-1:0] res_data,
  input  logic                      res_ready,
  output logic                      busy,
  output logic                      error,
  output logic                      ci_clk_en,
  output logic                      ci_start,
  output logic [N_WIDTH-1:0]        ci_n,
  output logic [FLT_DATA_WIDTH-1:0] ci_dataa,
  output logic [FLT_DATA_WIDTH-1:0] ci_datab,
  input  logic                      ci_done,
  input  logic [FLT_DATA_WIDTH-1:0] ci_result
);

  localparam logic [N_WIDTH-1:0] OP_CLEAR = N_WIDTH'(0);
  localparam logic [N_WIDTH-1:0] OP_GO    = N_WIDTH'(1);
  localparam logic [N_WIDTH-1:0] OP_READ  = N_WIDTH'(2);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR_ISSUE,
    S_CLR_WAIT,
    S_LOAD_A,
    S_LOAD_B,
    S_GO_ISSUE,
    S_GO_WAIT,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_OUTPUT
  } state_t;

  state_t                    r_state;
  logic [CNT_WIDTH-1:0]      r_remaining;
  logic                      r_busy;
  logic                      r_sample_ready;
  logic                      r_res_valid;
  logic [FLT_DATA_WIDTH-1:0] r_res_data;
  logic                      r_ci_clk_en;
  logic                      r_ci_start;
  logic [N_WIDTH-1:0]        r_ci_n;
  logic [FLT_DATA_WIDTH-1:0] r_ci_dataa;
  logic [FLT_DATA_WIDTH-1:0] r_ci_datab;

  logic w_sample_hs;
  logic w_more_samples;
  logic w_in_wait;

  assign w_sample_hs    = sample_valid & r_sample_ready;
  assign w_more_samples = (r_remaining != '0);
  assign w_in_wait      = (r_state == S_CLR_WAIT) || (r_state == S_GO_WAIT) ||
                          (r_state == S_RD_WAIT);

`ifdef FE_CI_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_error;
  logic            w_wd_expired;

  // Counter holds the number of cycles since ci_start rose: the ISSUE cycle
  // counts as the first, so expiry lands exactly TIMEOUT_CYCLES after launch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wd_cnt <= '0;
    end else if ((r_state == S_CLR_ISSUE) || (r_state == S_GO_ISSUE) ||
                 (r_state == S_RD_ISSUE)) begin
      r_wd_cnt <= WD_W'(1);
    end else if (w_in_wait) begin
      r_wd_cnt <= r_wd_cnt + WD_W'(1);
    end
  end

  assign w_wd_expired = w_in_wait && !ci_done &&
                        (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign error        = r_error;
`else
  assign error        = 1'b0;
`endif

  // Main sequencer: all handshake and instruction outputs are registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_remaining    <= '0;
      r_busy         <= 1'b0;
      r_sample_ready <= 1'b0;
      r_res_valid    <= 1'b0;
      r_res_data     <= '0;
      r_ci_clk_en    <= 1'b0;
      r_ci_start     <= 1'b0;
      r_ci_n         <= '0;
      r_ci_dataa     <= '0;
      r_ci_datab     <= '0;
`ifdef FE_CI_TIMEOUT_EN
      r_error        <= 1'b0;
`endif
    end else begin
      // ci_start is a one-cycle pulse, raised only on entry to an ISSUE state.
      r_ci_start <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (job_start) begin
            r_remaining <= job_count;
            r_busy      <= 1'b1;
            r_ci_clk_en <= 1'b1;
            r_ci_dataa  <= '0;
            r_ci_datab  <= '0;
            r_ci_start  <= 1'b1;
            r_ci_n      <= OP_CLEAR;
            r_state     <= S_CLR_ISSUE;
          end
        end

        S_CLR_ISSUE: r_state <= S_CLR_WAIT;
        S_GO_ISSUE:  r_state <= S_GO_WAIT;
        S_RD_ISSUE:  r_state <= S_RD_WAIT;

        S_CLR_WAIT, S_GO_WAIT: begin
          if (ci_done) begin
            if (w_more_samples) begin
              r_sample_ready <= 1'b1;
              r_state        <= S_LOAD_A;
            end else begin
              r_ci_start <= 1'b1;
              r_ci_n     <= OP_READ;
              r_state    <= S_RD_ISSUE;
            end
          end
        end

        S_LOAD_A: begin
          if (w_sample_hs) begin
            r_ci_dataa  <= sample_data;
            r_remaining <= r_remaining - CNT_WIDTH'(1);
            if (r_remaining == CNT_WIDTH'(1)) begin
              // Odd tail: pair the last sample with a zero x_two.
              r_ci_datab     <= '0;
              r_sample_ready <= 1'b0;
              r_ci_start     <= 1'b1;
              r_ci_n         <= OP_GO;
              r_state        <= S_GO_ISSUE;
            end else begin
              r_state <= S_LOAD_B;
            end
          end
        end

        S_LOAD_B: begin
          if (w_sample_hs) begin
            r_ci_datab     <= sample_data;
            r_remaining    <= r_remaining - CNT_WIDTH'(1);
            r_sample_ready <= 1'b0;
            r_ci_start     <= 1'b1;
            r_ci_n         <= OP_GO;
            r_state        <= S_GO_ISSUE;
          end
        end

        S_RD_WAIT: begin
          if (ci_done) begin
            r_res_data  <= ci_result;
            r_res_valid <= 1'b1;
            r_state     <= S_OUTPUT;
          end
        end

        S_OUTPUT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_ci_clk_en <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase

`ifdef FE_CI_TIMEOUT_EN
      // Watchdog expiry abandons the instruction and reports an all-ones result.
      if (w_wd_expired) begin
        r_error        <= 1'b1;
        r_res_data     <= '1;
        r_res_valid    <= 1'b1;
        r_sample_ready <= 1'b0;
        r_state        <= S_OUTPUT;
      end
`endif
    end
  end

  assign busy         = r_busy;
  assign sample_ready = r_sample_ready;
  assign res_valid    = r_res_valid;
  assign res_data     = r_res_data;
  assign ci_clk_en    = r_ci_clk_en;
  assign ci_start     = r_ci_start;
  assign ci_n         = r_ci_n;
  assign ci_dataa     = r_ci_dataa;
  assign ci_datab     = r_ci_datab;

endmodule

// File: tb/tb_fe_ci_initiator.sv
`timescale 1ns/1ps
module tb_fe_ci_initiator;

  localparam int unsigned W  = 32;
  localparam int unsigned NW = 2;
  localparam int unsigned CW = 16;
  localparam int unsigned TO = 16;

  localparam logic [31:0] F1 = 32'h3F80_0000;
  localparam logic [31:0] F2 = 32'h4000_0000;
  localparam logic [31:0] F3 = 32'h4040_0000;
  localparam logic [31:0] F4 = 32'h4080_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          job_start;
  logic [CW-1:0] job_count;
  logic          sample_valid;
  logic [W-1:0]  sample_data;
  logic          sample_ready;
  logic          res_valid;
  logic [W-1:0]  res_data;
  logic          res_ready;
  logic          busy;
  logic          error;
  logic          ci_clk_en;
  logic          ci_start;
  logic [NW-1:0] ci_n;
  logic [W-1:0]  ci_dataa;
  logic [W-1:0]  ci_datab;
  logic          ci_done;
  logic [W-1:0]  ci_result;

  fe_ci_initiator #(
    .FLT_DATA_WIDTH(W), .N_WIDTH(NW), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .job_start(job_start), .job_count(job_count),
    .sample_valid(sample_valid), .sample_data(sample_data), .sample_ready(sample_ready),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .busy(busy), .error(error),
    .ci_clk_en(ci_clk_en), .ci_start(ci_start), .ci_n(ci_n),
    .ci_dataa(ci_dataa), .ci_datab(ci_datab),
    .ci_done(ci_done), .ci_result(ci_result)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cmp_data;
  } instr_t;

  instr_t      exp_instr[$];
  logic [31:0] exp_res[$];
  int          n_checks  = 0;
  int          n_fail    = 0;
  int          start_cnt = 0;
  bit          sr_seen   = 1'b0;
  bit          hang_read = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %s, required none", name, what);
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({busy, sample_ready, res_valid, res_data, ci_clk_en, ci_start,
                 ci_n, ci_dataa, ci_datab, error});
  endfunction

  function automatic instr_t mk(input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, input bit cmp);
    instr_t t;
    t.op = op; t.a = a; t.b = b; t.cmp_data = cmp;
    return t;
  endfunction

  // Evaluator model: done three cycles after start; READ returns the sum of
  // (x_one ^ x_two) over the GOs since the last CLEAR.
  initial begin
    logic [1:0]  op;
    logic [31:0] acc;
    ci_done   = 1'b0;
    ci_result = '0;
    acc       = '0;
    forever begin
      @(negedge clk);
      if (rst && ci_start) begin
        op = ci_n;
        if (op == 2'd0) acc = '0;
        else if (op == 2'd1) acc = acc + (ci_dataa ^ ci_datab);
        if (!(op == 2'd2 && hang_read)) begin
          repeat (3) @(posedge clk);
          #1 ci_done = 1'b1;
          ci_result = (op == 2'd2) ? acc : 32'h0;
          @(posedge clk);
          #1 ci_done = 1'b0;
          ci_result = '0;
        end
      end
    end
  end

  // Scoreboard monitor: pops an expected entry whenever the DUT presents an
  // instruction launch or completes a result handoff.
  initial begin
    instr_t e;
    forever begin
      @(negedge clk);
      if (sample_ready) sr_seen = 1'b1;
      if (ci_start) begin
        start_cnt++;
        if (exp_instr.size() == 0) begin
          fail_now("instr_unexpected", "extra instruction");
        end else begin
          e = exp_instr.pop_front();
          if (e.cmp_data) check("instr", 128'({ci_n, ci_dataa, ci_datab}), 128'({e.op, e.a, e.b}));
          else            check("instr_op", 128'(ci_n), 128'(e.op));
        end
      end
      if (res_valid && res_ready) begin
        if (exp_res.size() == 0) fail_now("res_unexpected", "extra result");
        else check("res_data", 128'(res_data), 128'(exp_res.pop_front()));
      end
    end
  end

  task automatic start_job(input int count);
    job_count = CW'(count);
    job_start = 1'b1;
    @(posedge clk);
    #1 job_start = 1'b0;
  endtask

  task automatic send_sample(input logic [31:0] d, input int gap, input bit chk_gap);
    int base;
    int k;
    base = start_cnt;
    repeat (gap) @(posedge clk);
    #1;
    if (chk_gap) begin
      check("no_issue_in_gap", 128'(start_cnt), 128'(base));
      check("busy_clk_en_in_gap", 128'({busy, ci_clk_en}), 128'(2'b11));
    end
    sample_valid = 1'b1;
    sample_data  = d;
    k = 0;
    while (k < 1000) begin
      @(negedge clk);
      if (sample_ready) break;
      k++;
    end
    if (k == 1000) fail_now("sample_wait", "timeout");
    @(posedge clk);
    #1 sample_valid = 1'b0;
    sample_data = '0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (k < budget) begin
      @(negedge clk);
      if (!busy) break;
      k++;
    end
    if (k == budget) fail_now("wait_idle", "timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic check_drained(input string name);
    check({name, "_instr_q"}, 128'(exp_instr.size()), 128'(0));
    check({name, "_res_q"}, 128'(exp_res.size()), 128'(0));
  endtask

  initial begin
    int k;
    int base;
    job_start    = 1'b0;
    job_count    = '0;
    sample_valid = 1'b0;
    sample_data  = '0;
    res_ready    = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1 check("reset_outputs", all_outs(), 128'(0));
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Even job: CLEAR, GO(1,2), GO(3,4), READ
    exp_instr.push_back(mk(2'd0, 0, 0, 1'b1));
    exp_instr.push_back(mk(2'd1, F1, F2, 1'b1));
    exp_instr.push_back(mk(2'd1, F3, F4, 1'b1));
    exp_instr.push_back(mk(2'd2, 0, 0, 1'b0));
    exp_res.push_back(32'h8040_0000);
    start_job(4);
    send_sample(F1, 0, 1'b0);
    send_sample(F2, 0, 1'b0);
    send_sample(F3, 0, 1'b0);
    send_sample(F4, 0, 1'b0);
    wait_idle(300);
    check("job4_idle_outputs", 128'({busy, ci_clk_en, res_valid}), 128'(0));
    check_drained("job4");

    // Odd job: last GO padded with zero
    exp_instr.push_back(mk(2'd0, 0, 0, 1'b1));
    exp_instr.push_back(mk(2'd1, F1, F2, 1'b1));
    exp_instr.push_back(mk(2'd1, F3, 32'h0, 1'b1));
    exp_instr.push_back(mk(2'd2, 0, 0, 1'b0));
    exp_res.push_back(32'hBFC0_0000);
    start_job(3);
    send_sample(F1, 0, 1'b0);
    send_sample(F2, 0, 1'b0);
    send_sample(F3, 0, 1'b0);
    wait_idle(300);
    check_drained("job3");

    // Empty job: CLEAR then READ, no samples requested
    sr_seen = 1'b0;
    exp_instr.push_back(mk(2'd0, 0, 0, 1'b1));
    exp_instr.push_back(mk(2'd2, 0, 0, 1'b0));
    exp_res.push_back(32'h0);
    start_job(0);
    wait_idle(300);
    check("job0_sample_ready_seen", 128'(sr_seen), 128'(0));
    check_drained("job0");

    // Stalled job: sample gaps, held result, job_start while busy
    res_ready = 1'b0;
    exp_instr.push_back(mk(2'd0, 0, 0, 1'b1));
    exp_instr.push_back(mk(2'd1, F1, F2, 1'b1));
    exp_instr.push_back(mk(2'd1, F3, F4, 1'b1));
    exp_instr.push_back(mk(2'd2, 0, 0, 1'b0));
    exp_res.push_back(32'h8040_0000);
    start_job(4);
    send_sample(F1, 0, 1'b0);
    start_job(7);
    send_sample(F2, 10, 1'b1);
    send_sample(F3, 10, 1'b0);
    start_job(7);
    send_sample(F4, 10, 1'b1);
    k = 0;
    while (k < 300) begin
      @(negedge clk);
      if (res_valid) break;
      k++;
    end
    if (k == 300) fail_now("stall_res_wait", "timeout");
    for (int i = 0; i < 5; i++) begin
      check("stall_res_hold", 128'({res_valid, res_data}), 128'({1'b1, 32'h8040_0000}));
      @(negedge clk);
    end
    @(posedge clk);
    #1 res_ready = 1'b1;
    wait_idle(50);
    check_drained("stall");

    // Reset during GO_WAIT
    exp_instr.push_back(mk(2'd0, 0, 0, 1'b1));
    exp_instr.push_back(mk(2'd1, F1, F2, 1'b1));
    base = start_cnt;
    start_job(4);
    send_sample(F1, 0, 1'b0);
    send_sample(F2, 0, 1'b0);
    k = 0;
    while (k < 100 && start_cnt < base + 2) begin
      @(negedge clk);
      k++;
    end
    if (k == 100) fail_now("go_issue_wait", "timeout");
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check("midjob_reset_outputs", all_outs(), 128'(0));
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    check_drained("aborted");
    @(posedge clk);
    #1;

    // Fresh job after reset starts with CLEAR
    exp_instr.push_back(mk(2'd0, 0, 0, 1'b1));
    exp_instr.push_back(mk(2'd1, F1, F2, 1'b1));
    exp_instr.push_back(mk(2'd2, 0, 0, 1'b0));
    exp_res.push_back(32'h7F80_0000);
    start_job(2);
    send_sample(F1, 0, 1'b0);
    send_sample(F2, 0, 1'b0);
    wait_idle(300);
    check_drained("post_reset");

`ifdef FE_CI_TIMEOUT_EN
    // READ never completes: watchdog fires TO cycles after ci_start
    hang_read = 1'b1;
    res_ready = 1'b0;
    exp_instr.push_back(mk(2'd0, 0, 0, 1'b1));
    exp_instr.push_back(mk(2'd2, 0, 0, 1'b0));
    exp_res.push_back(32'hFFFF_FFFF);
    start_job(0);
    k = 0;
    while (k < 100) begin
      @(negedge clk);
      if (ci_start && ci_n == 2'd2) break;
      k++;
    end
    if (k == 100) fail_now("read_issue_wait", "timeout");
    repeat (TO - 1) @(posedge clk);
    #1 check("timeout_not_early", 128'({error, res_valid}), 128'(0));
    @(posedge clk);
    #1 check("timeout_fired", 128'({error, res_valid, res_data}), 128'({2'b11, 32'hFFFF_FFFF}));
    res_ready = 1'b1;
    wait_idle(50);
    check("error_sticky", 128'(error), 128'(1));
    check_drained("timeout");
    hang_read = 1'b0;
`else
    check("error_tied_low", 128'(error), 128'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got simulation still running, required completion");
    $fatal(1, "global timeout");
  end

endmodule
